// File: rtl/ula_pkg.sv
// Shared opcodes and FSM encoding for the registered ULA and its multiplier.
package ula_pkg;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MAIOR = 3'b010;
  localparam logic [2:0] OP_MENOR = 3'b011;
  localparam logic [2:0] OP_IGUAL = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/ula_mul.sv
// Unsigned WIDTH x WIDTH shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start; done pulses for one cycle with the product on p.
module ula_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      // Last step: the product lands in acc_q on the same edge done rises.
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = acc_q;
endmodule

// File: rtl/ula_seq.sv
// Registered ULA with valid/ready handshake on both sides; single-cycle ops
// finish in one cycle, MUL goes through the multi-cycle ula_mul unit.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_z;
  logic               alu_c, alu_o;
  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_p;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // diff[WIDTH] is the borrow, i.e. A < B unsigned.
  always_comb begin
    alu_z = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (func)
      OP_ADD: begin
        alu_z = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_o = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_z = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_o = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MAIOR: alu_z = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_MENOR: alu_z = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_IGUAL: alu_z = {{(WIDTH-1){1'b0}}, (A == B)};
      OP_XOR:   alu_z = A ^ B;
      OP_AND:   alu_z = A & B;
      default:  alu_z = '0;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    mul_start = 1'b0;
    case (state_q)
      ST_MUL: begin
        if (mul_done && !mul_busy) begin
          z_d     = mul_p[WIDTH-1:0];
          zero_d  = (mul_p[WIDTH-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = |mul_p[2*WIDTH-1:WIDTH];
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (out_ready && !in_valid) state_d = ST_IDLE;
      default: ;
    endcase
    // A new command in DONE overrides the drop to IDLE above.
    if (accept) begin
      if (func == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = ST_MUL;
      end else begin
        z_d     = alu_z;
        zero_d  = (alu_z == '0);
        carry_d = alu_c;
        ovf_d   = alu_o;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  ula_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign Z     = z_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq (WIDTH=4): vector table plus hand-written handshake,
// latency, stall and reset sequences, all checked through a result scoreboard.
module tb_ula_seq;
  typedef struct packed {
    logic [3:0] z;
    logic       zero;
    logic       carry;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [2:0] f;
    logic [3:0] a;
    logic [3:0] b;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [2:0] func;
  logic [3:0] A, B;
  logic       out_valid, out_ready;
  logic [3:0] Z;
  logic       zero, carry, ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t scb[$];
  int   xq[$];
  exp_t mon_e;
  vec_t vecs[16];

  ula_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .zero      (zero),
    .carry     (carry),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent integer reference for the random phase.
  function automatic exp_t model(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int ia, ib, sa, sbv, r;
    ia = int'(a);
    ib = int'(b);
    sa  = (ia > 7) ? ia - 16 : ia;
    sbv = (ib > 7) ? ib - 16 : ib;
    e = '0;
    case (f)
      3'd0: begin r = ia + ib; e.z = 4'(r % 16); e.carry = (r > 15);
                  e.ovf = (sa + sbv > 7) || (sa + sbv < -8); end
      3'd1: begin r = ia - ib; e.z = 4'((r + 16) % 16); e.carry = (ia < ib);
                  e.ovf = (sa - sbv > 7) || (sa - sbv < -8); end
      3'd2: e.z = (ia > ib) ? 4'd1 : 4'd0;
      3'd3: e.z = (ia < ib) ? 4'd1 : 4'd0;
      3'd4: e.z = (ia == ib) ? 4'd1 : 4'd0;
      3'd5: e.z = a ^ b;
      3'd6: e.z = a & b;
      default: begin r = ia * ib; e.z = 4'(r % 16); e.ovf = (r > 15); end
    endcase
    e.zero = (e.z == 4'd0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b, input exp_t e);
    int n = 0;
    func = f; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end else scb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 4'hx; B = 4'hx; func = 3'bxxx;
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (scb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", scb.size());
      scb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xq.push_back(cyc);
      if (scb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got Z=%0d with no result outstanding", Z);
      end else begin
        mon_e = scb.pop_front();
        chk("result {Z,zero,carry,ovf}", {25'd0, Z, zero, carry, ovf}, {25'd0, mon_e});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; func = '0; A = '0; B = '0;
    vecs[0]  = '{3'd0, 4'd9,  4'd8,  '{4'd1,  1'b0, 1'b1, 1'b1}};
    vecs[1]  = '{3'd1, 4'd3,  4'd5,  '{4'd14, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{3'd4, 4'd6,  4'd6,  '{4'd1,  1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{3'd3, 4'd6,  4'd6,  '{4'd0,  1'b1, 1'b0, 1'b0}};
    vecs[4]  = '{3'd2, 4'd7,  4'd2,  '{4'd1,  1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{3'd7, 4'd7,  4'd3,  '{4'd5,  1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{3'd7, 4'd3,  4'd5,  '{4'd15, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{3'd0, 4'd0,  4'd0,  '{4'd0,  1'b1, 1'b0, 1'b0}};
    vecs[8]  = '{3'd1, 4'd8,  4'd1,  '{4'd7,  1'b0, 1'b0, 1'b1}};
    vecs[9]  = '{3'd5, 4'd5,  4'd5,  '{4'd0,  1'b1, 1'b0, 1'b0}};
    vecs[10] = '{3'd6, 4'd12, 4'd10, '{4'd8,  1'b0, 1'b0, 1'b0}};
    vecs[11] = '{3'd7, 4'd15, 4'd15, '{4'd1,  1'b0, 1'b0, 1'b1}};
    vecs[12] = '{3'd0, 4'd7,  4'd1,  '{4'd8,  1'b0, 1'b0, 1'b1}};
    vecs[13] = '{3'd2, 4'd2,  4'd7,  '{4'd0,  1'b1, 1'b0, 1'b0}};
    vecs[14] = '{3'd7, 4'd0,  4'd9,  '{4'd0,  1'b1, 1'b0, 1'b0}};
    vecs[15] = '{3'd1, 4'd5,  4'd5,  '{4'd0,  1'b1, 1'b0, 1'b0}};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst Z", Z, 0);
    chk("rst flags", {zero, carry, ovf}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) send(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].e);
    drain();

    // MUL latency; inputs change right after accept and must not matter.
    func = 3'd7; A = 4'd7; B = 4'd3; in_valid = 1'b1;
    scb.push_back('{4'd5, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    in_valid = 1'b0; A = 4'd0; B = 4'd0; func = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("mul out_valid low", out_valid, 0);
      if (k <= 4) chk("mul in_ready low", in_ready, 0);
    end
    @(negedge clk);
    chk("mul out_valid at accept+5", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Back-to-back single-cycle ops transfer on consecutive cycles.
    xq.delete();
    send(3'd5, 4'd12, 4'd10, '{4'd6, 1'b0, 1'b0, 1'b0});
    send(3'd6, 4'd12, 4'd10, '{4'd8, 1'b0, 1'b0, 1'b0});
    send(3'd0, 4'd2,  4'd3,  '{4'd5, 1'b0, 1'b0, 1'b0});
    drain();
    chk("b2b count", xq.size(), 3);
    if (xq.size() == 3) begin
      chk("b2b gap 1", xq[1] - xq[0], 1);
      chk("b2b gap 2", xq[2] - xq[1], 1);
    end

    // Consumer stall: result must hold.
    out_ready = 1'b0;
    send(3'd0, 4'd9, 4'd8, '{4'd1, 1'b0, 1'b1, 1'b1});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall out_valid", out_valid, 1);
      chk("stall Z", Z, 1);
      chk("stall flags", {zero, carry, ovf}, 3'b011);
      chk("stall in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset while the multiplier is on step 2; result must be discarded.
    func = 3'd7; A = 4'd7; B = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midmul rst out_valid", out_valid, 0);
    chk("midmul rst Z", Z, 0);
    chk("midmul rst flags", {zero, carry, ovf}, 0);
    chk("midmul rst in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midmul no late result", out_valid, 0);
    end
    @(posedge clk); #1;
    send(3'd0, 4'd1, 4'd1, '{4'd2, 1'b0, 1'b0, 1'b0});
    drain();

    // Reset wins over a simultaneous command.
    func = 3'd0; A = 4'd3; B = 4'd4; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst priority out_valid", out_valid, 0);
    chk("rst priority Z", Z, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      logic [2:0] f;
      logic [3:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      send(f, a, b, model(f, a, b));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
